// File: rtl/qkd_event_writer.sv
// Detector-click capture: timestamps events, queues them in a skid FIFO and writes them into a
// ping-pong event RAM with per-half IRQs. Optional epoch markers: define QKD_TS_EPOCH_EN.
module qkd_event_writer #(
    parameter int ADDR_W     = 11,
    parameter int TS_W       = 12,
    parameter int DET_W      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_W     = 16
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              capture_en,
    input  logic              det_valid,
    input  logic [DET_W-1:0]  det_bits,
    input  logic [1:0]        irq_ack,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_clken,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [15:0]       mem_writedata,
    output logic [1:0]        mem_byteenable,
    output logic [1:0]        irq_half,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] HALF0_LAST = ADDR_W'((1 << (ADDR_W - 1)) - 1);

    logic [TS_W-1:0]   r_ts;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [15:0]       r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [1:0]        r_full;
    logic [ADDR_W-1:0] r_mem_address;
    logic              r_mem_write;
    logic [15:0]       r_mem_writedata;
    logic              r_overflow;
    logic [DROP_W-1:0] r_drop_count;

    logic              w_evt;
    logic [15:0]       w_evt_word;
    logic              w_pop;
    logic [CNT_W-1:0]  w_free;
    logic              w_req0;
    logic              w_req1;
    logic [15:0]       w_word0;
    logic [15:0]       w_word1;
    logic              w_acc0;
    logic              w_acc1;
    logic [1:0]        w_ndrop;
    logic [DROP_W:0]   w_drop_sum;
    logic [1:0]        w_full_set;
    logic [PTR_W-1:0]  w_tail1;

    assign w_evt      = det_valid & capture_en & (|det_bits);
    assign w_evt_word = {det_bits, r_ts};

    // The writer only stalls on the half that wr_ptr currently points into.
    assign w_pop  = (r_count != '0) && !r_full[r_wr_ptr[ADDR_W-1]];
    assign w_free = CNT_W'(FIFO_DEPTH) - r_count + CNT_W'(w_pop);

`ifdef QKD_TS_EPOCH_EN
    logic [TS_W-1:0] r_epoch;
    logic            w_wrap;
    logic [TS_W-1:0] w_epoch_next;

    assign w_wrap       = &r_ts;
    assign w_epoch_next = r_epoch + TS_W'(1);
    // On a wrap edge the marker occupies slot 0 and a coincident event moves to slot 1.
    assign w_req0  = w_wrap | w_evt;
    assign w_word0 = w_wrap ? {(16 - TS_W)'(0), w_epoch_next} : w_evt_word;
    assign w_req1  = w_wrap & w_evt;
    assign w_word1 = w_evt_word;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_epoch <= '0;
        end else if (w_wrap) begin
            r_epoch <= w_epoch_next;
        end
    end
`else
    assign w_req0  = w_evt;
    assign w_word0 = w_evt_word;
    assign w_req1  = 1'b0;
    assign w_word1 = w_evt_word;
`endif

    assign w_acc0     = w_req0 && (w_free != '0);
    assign w_acc1     = w_req1 && (w_free >= CNT_W'(2));
    assign w_ndrop    = 2'(w_req0 & !w_acc0) + 2'(w_req1 & !w_acc1);
    assign w_drop_sum = {1'b0, r_drop_count} + (DROP_W + 1)'(w_ndrop);
    assign w_tail1    = r_tail + PTR_W'(1);

    assign w_full_set[0] = w_pop && (r_wr_ptr == HALF0_LAST);
    assign w_full_set[1] = w_pop && (&r_wr_ptr);

    // NOTE: every register here, FIFO storage included, is reset so a reset mid-burst leaves
    // no stale word that a later pointer wrap could expose; the array is only FIFO_DEPTH deep.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_ts            <= '0;
            r_wr_ptr        <= '0;
            r_head          <= '0;
            r_tail          <= '0;
            r_count         <= '0;
            r_full          <= '0;
            r_mem_address   <= '0;
            r_mem_write     <= 1'b0;
            r_mem_writedata <= '0;
            r_overflow      <= 1'b0;
            r_drop_count    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments throughout, so every read below sees the
            // pre-edge value regardless of statement order.
            r_ts <= r_ts + TS_W'(1);

            if (w_acc0) r_fifo[r_tail]  <= w_word0;
            if (w_acc1) r_fifo[w_tail1] <= w_word1;
            r_tail  <= r_tail + PTR_W'(w_acc0) + PTR_W'(w_acc1);
            r_count <= r_count + CNT_W'(w_acc0) + CNT_W'(w_acc1) - CNT_W'(w_pop);

            r_mem_write <= w_pop;
            if (w_pop) begin
                r_head          <= r_head + PTR_W'(1);
                r_mem_address   <= r_wr_ptr;
                r_mem_writedata <= r_fifo[r_head];
                r_wr_ptr        <= r_wr_ptr + ADDR_W'(1);
            end

            // A half is never set and acked on the same edge: set requires full[h]==0.
            r_full <= (r_full & ~irq_ack) | w_full_set;

            if (w_ndrop != 2'd0) begin
                r_overflow   <= 1'b1;
                r_drop_count <= w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
            end
        end
    end

    assign mem_address    = r_mem_address;
    assign mem_clken      = 1'b1;
    assign mem_chipselect = r_mem_write;
    assign mem_write      = r_mem_write;
    assign mem_writedata  = r_mem_writedata;
    assign mem_byteenable = 2'b11;
    assign irq_half       = r_full;
    assign overflow       = r_overflow;
    assign drop_count     = r_drop_count;

endmodule

// File: tb/tb_qkd_event_writer.sv
// Directed bench for qkd_event_writer: reset, latency, half fill/IRQ, stall/drop, FIFO boundary,
// timestamp wrap, capture gating and reset mid-burst. Expected words come from a local ts model.
module tb_qkd_event_writer;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        capture_en;
    logic        det_valid;
    logic [3:0]  det_bits;
    logic [1:0]  irq_ack;
    logic [10:0] mem_address;
    logic        mem_clken;
    logic        mem_chipselect;
    logic        mem_write;
    logic [15:0] mem_writedata;
    logic [1:0]  mem_byteenable;
    logic [1:0]  irq_half;
    logic        overflow;
    logic [15:0] drop_count;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [11:0] tb_ts = '0;
    logic        mon_on = 1'b0;
    logic [15:0] exp_words [5];

    always #5 clk_clk = ~clk_clk;

    qkd_event_writer dut (
        .clk_clk        (clk_clk),
        .reset_reset_n  (reset_reset_n),
        .capture_en     (capture_en),
        .det_valid      (det_valid),
        .det_bits       (det_bits),
        .irq_ack        (irq_ack),
        .mem_address    (mem_address),
        .mem_clken      (mem_clken),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_byteenable (mem_byteenable),
        .irq_half       (irq_half),
        .overflow       (overflow),
        .drop_count     (drop_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        logic rst_at;
        rst_at = reset_reset_n;
        @(posedge clk_clk);
        #1;
        tb_ts = rst_at ? tb_ts + 12'd1 : 12'd0;
    endtask

    task automatic expect_write(input string tag, input logic [10:0] addr, input logic [15:0] data);
        check({tag, "_we"}, mem_write, 1'b1);
        check({tag, "_addr"}, mem_address, addr);
        check({tag, "_data"}, mem_writedata, data);
    endtask

    task automatic push_run(input int n);
        for (int i = 0; i < n; i++) begin
            det_bits  = 4'(i % 15 + 1);
            det_valid = 1'b1;
            tick();
        end
        det_valid = 1'b0;
    endtask

    always @(negedge clk_clk) begin
        if (mon_on) check("cs_tracks_we", mem_chipselect, mem_write);
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset_reset_n = 1'b0;
        capture_en    = 1'b1;
        det_valid     = 1'b0;
        det_bits      = 4'h0;
        irq_ack       = 2'b00;

        // T1 reset
        repeat (3) tick();
        check("rst_we", mem_write, 1'b0);
        check("rst_cs", mem_chipselect, 1'b0);
        check("rst_addr", mem_address, 11'd0);
        check("rst_data", mem_writedata, 16'h0000);
        check("rst_clken", mem_clken, 1'b1);
        check("rst_be", mem_byteenable, 2'b11);
        check("rst_irq", irq_half, 2'b00);
        check("rst_ovf", overflow, 1'b0);
        check("rst_drop", drop_count, 16'd0);
        reset_reset_n = 1'b1;
        mon_on = 1'b1;

        // T2 single event sampled at ts=0x005
        repeat (5) tick();
        det_bits  = 4'b0010;
        det_valid = 1'b1;
        tick();
        det_valid = 1'b0;
        check("t2_not_yet", mem_write, 1'b0);
        tick();
        expect_write("t2", 11'd0, 16'h2005);
        check("t2_irq", irq_half, 2'b00);

        // T3 fill half0 (addr 1..1023), IRQ on the edge writing 1023
        push_run(1023);
        check("t3_addr1022", mem_address, 11'd1022);
        check("t3_irq_before", irq_half, 2'b00);
        tick();
        expect_write("t3_last", 11'd1023, mem_writedata);
        check("t3_irq", irq_half, 2'b01);
        tick();
        check("t3_idle", mem_write, 1'b0);
        det_bits     = 4'h8;
        exp_words[0] = {4'h8, tb_ts};
        det_valid    = 1'b1;
        tick();
        det_valid = 1'b0;
        tick();
        expect_write("t3_next", 11'd1024, exp_words[0]);

        // T4 fill half1, stall at wrap, 6 events -> 4 queued, 2 dropped
        push_run(1023);
        tick();
        check("t4_addr2047", mem_address, 11'd2047);
        check("t4_irq", irq_half, 2'b11);
        tick();
        for (int i = 0; i < 6; i++) begin
            det_bits = 4'(i + 1);
            if (i < 4) exp_words[i] = {4'(i + 1), tb_ts};
            det_valid = 1'b1;
            tick();
            check("t4_stall", mem_write, 1'b0);
        end
        det_valid = 1'b0;
        repeat (2) tick();
        check("t4_stall_hold", mem_write, 1'b0);
        check("t4_drop", drop_count, 16'd2);
        check("t4_ovf", overflow, 1'b1);
        irq_ack = 2'b01;
        tick();
        irq_ack = 2'b00;
        check("t4_ack_irq", irq_half, 2'b10);
        check("t4_ack_nowr", mem_write, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_write("t4_drain", 11'(i), exp_words[i]);
        end
        tick();
        check("t4_drained", mem_write, 1'b0);

        // T5 full FIFO with half free: push and pop on the same edge, no drop
        push_run(1020);
        tick();
        check("t5_addr1023", mem_address, 11'd1023);
        check("t5_irq", irq_half, 2'b11);
        tick();
        for (int i = 0; i < 4; i++) begin
            det_bits     = 4'(i + 9);
            exp_words[i] = {4'(i + 9), tb_ts};
            det_valid    = 1'b1;
            tick();
        end
        det_valid = 1'b0;
        check("t5_stall", mem_write, 1'b0);
        irq_ack = 2'b10;
        tick();
        irq_ack = 2'b00;
        check("t5_ack_irq", irq_half, 2'b01);
        det_bits     = 4'hD;
        exp_words[4] = {4'hD, tb_ts};
        det_valid    = 1'b1;
        tick();
        det_valid = 1'b0;
        check("t5_nodrop", drop_count, 16'd2);
        expect_write("t5_w0", 11'd1024, exp_words[0]);
        for (int i = 1; i < 5; i++) begin
            tick();
            expect_write("t5_w", 11'(1024 + i), exp_words[i]);
        end
        tick();
        check("t5_only5", mem_write, 1'b0);

        // T6 event on the ts wrap edge (ts=0xFFF sampled)
        for (int k = 0; k < 4096 && tb_ts != 12'hFFF; k++) tick();
        det_bits  = 4'hA;
        det_valid = 1'b1;
        tick();
        det_valid = 1'b0;
        tick();
`ifdef QKD_TS_EPOCH_EN
        expect_write("t6_marker", 11'd1029, 16'h0001);
        tick();
        expect_write("t6_evt", 11'd1030, 16'hAFFF);
`else
        expect_write("t6_evt", 11'd1029, 16'hAFFF);
`endif
        tick();
        check("t6_no_marker", mem_write, 1'b0);

        // T7 capture_en=0 and det_bits=0 are both ignored
        capture_en = 1'b0;
        det_bits   = 4'h3;
        det_valid  = 1'b1;
        repeat (2) tick();
        check("t7_cap_off", mem_write, 1'b0);
        capture_en = 1'b1;
        det_bits   = 4'h0;
        repeat (2) tick();
        det_valid = 1'b0;
        check("t7_zero_bits", mem_write, 1'b0);

        // T8 reset mid-burst discards the queue and the in-flight write
        push_run(3);
        check("t8_busy", mem_write, 1'b1);
        reset_reset_n = 1'b0;
        tick();
        reset_reset_n = 1'b1;
        check("t8_we", mem_write, 1'b0);
        check("t8_addr", mem_address, 11'd0);
        check("t8_drop", drop_count, 16'd0);
        check("t8_ovf", overflow, 1'b0);
        check("t8_irq", irq_half, 2'b00);
        repeat (2) tick();
        check("t8_flushed", mem_write, 1'b0);

        mon_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
